// File: rtl/prod_pkg.sv
// prod_pkg: shared state encoding and default widths for the product accumulator
package prod_pkg;
  localparam int PW_DEF = 7;
  localparam int LW_DEF = 4;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
endpackage

// File: rtl/prod_accum_ctrl.sv
// prod_accum_ctrl: burst FSM deciding when products are taken and when the sum is offered
module prod_accum_ctrl
  import prod_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start_i,
  input  logic   len_nz_i,
  input  logic   in_valid_i,
  input  logic   last_i,
  input  logic   out_ready_i,
  output state_e state_o,
  output logic   in_ready_o,
  output logic   out_valid_o,
  output logic   busy_o
);
  state_e state_q, state_d;
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // next state and state-only handshake outputs
  always_comb begin
    state_d = state_q;
    in_ready_o = state_q == ACC;
    out_valid_o = state_q == DONE;
    busy_o = state_q != IDLE;
    case (state_q)
      IDLE: state_d = start_i && len_nz_i ? ACC : IDLE;
      ACC:  state_d = in_valid_i && last_i ? DONE : ACC;
      DONE: state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign state_o = state_q;
endmodule

// File: rtl/prod_accum.sv
// prod_accum: accumulates a burst of len unsigned products and hands the sum downstream
module prod_accum
  import prod_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int LW = LW_DEF,
  parameter int SW = PW + LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  input  logic [PW-1:0] prod,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] sum,
  output logic [LW-1:0] count,
  output logic          busy
);
  state_e        state;
  logic [SW-1:0] sum_q, sum_d;
  logic [LW-1:0] count_q, count_d, len_q, len_d, count_inc;
  logic          load, xfer;
  assign count_inc = count_q + 1'b1;
  assign load = state == IDLE && start && len != '0;
  assign xfer = in_valid && in_ready;
  prod_accum_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .len_nz_i    (len != '0),
    .in_valid_i  (in_valid),
    .last_i      (count_inc == len_q),
    .out_ready_i (out_ready),
    .state_o     (state),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .busy_o      (busy)
  );
  // datapath next state: clear on accepted start, accumulate on transfer
  always_comb begin
    sum_d = load ? '0 : xfer ? sum_q + {{LW{1'b0}}, prod} : sum_q;
    count_d = load ? '0 : xfer ? count_inc : count_q;
    len_d = load ? len : len_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    sum_q <= rst ? '0 : sum_d;
    count_q <= rst ? '0 : count_d;
    len_q <= rst ? '0 : len_d;
  end
  assign sum = sum_q;
  assign count = count_q;
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed and randomized checks of the product accumulator
module tb_prod_accum;
  logic       clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [3:0] len = 0, count;
  logic [6:0] prod = 0;
  logic       in_ready, out_valid, busy;
  logic [10:0] sum;
  int total = 0, bad = 0;
  prod_accum dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .prod(prod), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .count(count), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  initial begin
    int exp_sum, n, l, g;
    cyc();
    cyc();
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    // reset mid-burst
    start = 1; len = 4;
    cyc();
    start = 0;
    check("acc_busy", busy, 1);
    check("acc_in_ready", in_ready, 1);
    in_valid = 1; prod = 5;
    cyc();
    prod = 7;
    cyc();
    in_valid = 0;
    check("mid_sum", sum, 12);
    check("mid_count", count, 2);
    rst = 1; start = 1; in_valid = 1; out_ready = 1;
    cyc();
    rst = 0; start = 0; in_valid = 0;
    check("midrst_sum", sum, 0);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    // basic back-to-back burst
    start = 1; len = 3;
    cyc();
    start = 0; len = 9; in_valid = 1; prod = 6;
    cyc();
    check("b_out_valid_early", out_valid, 0);
    prod = 21;
    cyc();
    prod = 105;
    cyc();
    in_valid = 0;
    check("b_out_valid", out_valid, 1);
    check("b_sum", sum, 132);
    check("b_count", count, 3);
    check("b_in_ready", in_ready, 0);
    cyc();
    check("b_out_valid_drop", out_valid, 0);
    check("b_busy_drop", busy, 0);
    check("b_sum_held", sum, 132);
    check("b_count_held", count, 3);
    // gapped valid, with a start during ACC that must be ignored
    start = 1; len = 2;
    cyc();
    start = 0; in_valid = 1; prod = 10;
    cyc();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("g_in_ready", in_ready, 1);
      start = i == 1; len = 7;
      cyc();
    end
    start = 0;
    in_valid = 1; prod = 20;
    cyc();
    in_valid = 0;
    check("g_out_valid", out_valid, 1);
    check("g_sum", sum, 30);
    check("g_count", count, 2);
    cyc();
    check("g_idle", busy, 0);
    // backpressure, with a start during DONE that must be ignored
    out_ready = 0; start = 1; len = 1;
    cyc();
    start = 0; in_valid = 1; prod = 9;
    cyc();
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, 9);
      check("bp_in_ready", in_ready, 0);
      start = i == 2; len = 5;
      cyc();
    end
    start = 0;
    check("bp_count", count, 1);
    out_ready = 1;
    cyc();
    check("bp_out_valid_drop", out_valid, 0);
    check("bp_idle", busy, 0);
    // len == 0 ignored
    start = 1; len = 0;
    cyc();
    start = 0;
    check("len0_busy", busy, 0);
    check("len0_sum", sum, 9);
    check("len0_count", count, 1);
    // maximum burst
    start = 1; len = 15;
    cyc();
    start = 0; in_valid = 1; prod = 127;
    repeat (15) cyc();
    in_valid = 0;
    check("max_out_valid", out_valid, 1);
    check("max_sum", sum, 1905);
    check("max_count", count, 15);
    cyc();
    check("max_idle", busy, 0);
    // random bursts against a bench-side running sum
    for (int b = 0; b < 10; b++) begin
      l = $urandom_range(15, 1);
      start = 1; len = 4'(l);
      cyc();
      start = 0; len = 4'($urandom);
      exp_sum = 0; n = 0; g = 0;
      while (n < l && g < 200) begin
        check("r_in_ready", in_ready, 1);
        in_valid = 1'($urandom_range(1, 0));
        prod = 7'($urandom_range(105, 0));
        out_ready = 1'($urandom);
        if (in_valid) begin
          exp_sum += int'(prod);
          n++;
        end
        g++;
        cyc();
      end
      in_valid = 0;
      check("r_out_valid", out_valid, 1);
      check("r_sum", sum, exp_sum);
      check("r_count", count, l);
      repeat ($urandom_range(3, 0)) begin
        out_ready = 0;
        cyc();
        check("r_hold", out_valid, 1);
      end
      out_ready = 1;
      cyc();
      check("r_idle", busy, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 SHALL have parameter PW, default 7, meaning width of the incoming product word.
REQ-002 SHALL have parameter LW, default 4, meaning width of the burst-length field; SW = PW+LW derived, default 11.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-006 SHALL have port len  input  LW  number of products to accumulate, sampled with start.
REQ-007 SHALL have port in_valid  input  1  upstream product valid.
REQ-008 SHALL have port prod  input  PW  unsigned product from the upstream multiplier stage.
REQ-009 SHALL have port in_ready  output  1  block accepts prod this cycle.
REQ-010 SHALL have port out_valid  output  1  sum result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts sum.
REQ-012 SHALL have port sum  output  SW  accumulated unsigned sum.
REQ-013 SHALL have port count  output  LW  products accepted so far in the current burst.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 with len!=0 latches len, clears sum and count to 0, and enters ACC on the next edge.
REQ-017 IDLE: start=1 with len==0 SHALL be ignored (state, sum, count unchanged).
REQ-018 ACC: in_ready=1 combinationally from state only, never dependent on in_valid.
REQ-019 ACC: a transfer occurs when in_valid && in_ready; then sum <= sum + zero-extended prod and count <= count+1 on that edge.
REQ-020 ACC: the transfer that makes count+1 equal to the latched len SHALL move to DONE on the same edge; no transfer leaves state unchanged.
REQ-021 SW is sized so that len_max*(2^PW-1) never overflows (15*127=1905 < 2048); no saturation or wrap logic is needed.
REQ-022 DONE: in_ready=0, out_valid=1, sum and count held stable until handshake.
REQ-023 DONE: out_valid && out_ready SHALL return to IDLE on that edge; out_valid low the next cycle; sum and count retain final values in IDLE until next start.
REQ-024 start asserted in ACC or DONE SHALL be ignored; len changes after start have no effect.
REQ-025 Result latency SHALL be exactly len accepted transfers plus one start cycle; a back-to-back valid stream of length L gives out_valid on cycle L+1 after start.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, sum=0, count=0, latched len=0, in_ready=0, out_valid=0, busy=0.
REQ-027 rst SHALL dominate start, in_valid and out_ready in the same cycle, including mid-burst (partial sum discarded).

Structure
REQ-028 State enumeration and default PW/LW constants SHALL live in shared package prod_pkg.
REQ-029 FSM next-state logic MAY be split into sub-module prod_accum_ctrl; datapath (sum, count, len registers) stays in prod_accum.

Verification
REQ-030 Reset mid-burst: start len=4, accept 2 products (5,7), assert rst -> sum=0, count=0, busy=0 next cycle.
REQ-031 Basic burst: start len=3, prod 6,21,105 back-to-back with out_ready=1 -> out_valid one cycle with sum=132, count=3.
REQ-032 Gapped valid: start len=2, prod 10, idle 3 cycles, prod 20 -> sum=30, in_ready stays 1 through gaps.
REQ-033 Backpressure: finish len=1 prod=9 with out_ready=0 for 5 cycles -> out_valid and sum=9 held, in_ready=0, then IDLE one cycle after out_ready=1.
REQ-034 Corner: start len=0 -> stays IDLE; start len=15 with prod=127 each -> sum=1905, no overflow.
REQ-035 Random: 10 bursts of random len 1..15 and prod 0..105 with random valid/ready -> sum matches reference model every burst.
